// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, prefetches into a small FIFO,
// and hands {pc, instr} pairs to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CONE = 1;
  localparam logic [AW-1:0] PONE = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  entry_t        head;
  logic [31:0]   pc;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          misaligned;

  assign imem_addr  = pc;
  assign dec_valid  = (count != '0);
  assign head       = fifo_q[rd_ptr];
  assign dec_pc     = dec_valid ? head.pc : '0;
  assign dec_instr  = dec_valid ? head.instr : '0;
  assign pop        = dec_valid & dec_ready;
  assign push       = !redirect_valid & !fetch_fault &
                      ((count != FULL_C) | pop);
  assign misaligned = |redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= '{pc: pc, instr: imem_instr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      // A same-cycle pop is already consumed by decode; flush the rest.
      pc          <= redirect_pc;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_fault <= misaligned;
      if (misaligned)
        fault_pc <= redirect_pc;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PONE;
        pc     <= pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PONE;
      unique case ({push, pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

endmodule
